// File: rtl/match_controller.sv
// Match sequencing for the two-player LED tug game: rounds, pauses, scores and winner.
// Optional round counter output enabled by defining MATCH_CTRL_ROUND_CNT_EN.
module match_controller #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       point_l,
  input  logic       point_r,
  output logic       field_clear,
  output logic       play_en,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic       game_over,
  output logic [1:0] winner
`ifdef MATCH_CTRL_ROUND_CNT_EN
  ,
  output logic [3:0] round_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [2:0]  WIN        = 3'(WIN_SCORE);
  localparam logic [15:0] PAUSE_LOAD = 16'(PAUSE_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pause_cnt, w_pause_cnt_nxt;
  logic [2:0]  r_score_l, w_score_l_nxt;
  logic [2:0]  r_score_r, w_score_r_nxt;
  logic        r_game_over, w_game_over_nxt;
  logic [1:0]  r_winner, w_winner_nxt;
  logic        r_field_clear;
  logic        r_play_en;
  logic [2:0]  w_inc_l, w_inc_r;

  assign w_inc_l = r_score_l + 3'd1;
  assign w_inc_r = r_score_r + 3'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_pause_cnt_nxt = r_pause_cnt;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    w_game_over_nxt = r_game_over;
    w_winner_nxt    = r_winner;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt     = S_CLEAR;
          w_score_l_nxt   = '0;
          w_score_r_nxt   = '0;
          w_game_over_nxt = 1'b0;
          w_winner_nxt    = '0;
        end
      end
      S_CLEAR: w_state_nxt = S_PLAY;
      S_PLAY: begin
        // Simultaneous arrival is a draw: nobody scores, the round is replayed.
        if (point_l && point_r) begin
          w_state_nxt     = S_PAUSE;
          w_pause_cnt_nxt = PAUSE_LOAD;
        end else if (point_l) begin
          w_score_l_nxt = w_inc_l;
          if (w_inc_l == WIN) begin
            w_state_nxt     = S_DONE;
            w_game_over_nxt = 1'b1;
            w_winner_nxt    = 2'b10;
          end else begin
            w_state_nxt     = S_PAUSE;
            w_pause_cnt_nxt = PAUSE_LOAD;
          end
        end else if (point_r) begin
          w_score_r_nxt = w_inc_r;
          if (w_inc_r == WIN) begin
            w_state_nxt     = S_DONE;
            w_game_over_nxt = 1'b1;
            w_winner_nxt    = 2'b01;
          end else begin
            w_state_nxt     = S_PAUSE;
            w_pause_cnt_nxt = PAUSE_LOAD;
          end
        end
      end
      S_PAUSE: begin
        if (r_pause_cnt == '0) w_state_nxt = S_PLAY;
        else                   w_pause_cnt_nxt = r_pause_cnt - 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pause_cnt   <= '0;
      r_score_l     <= '0;
      r_score_r     <= '0;
      r_game_over   <= 1'b0;
      r_winner      <= '0;
      r_field_clear <= 1'b1;
      r_play_en     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pause_cnt   <= w_pause_cnt_nxt;
      r_score_l     <= w_score_l_nxt;
      r_score_r     <= w_score_r_nxt;
      r_game_over   <= w_game_over_nxt;
      r_winner      <= w_winner_nxt;
      // Registered decode of the next state keeps the strobes aligned with it.
      r_field_clear <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CLEAR) ||
                       (w_state_nxt == S_PAUSE);
      r_play_en     <= (w_state_nxt == S_PLAY);
    end
  end

  assign field_clear = r_field_clear;
  assign play_en     = r_play_en;
  assign score_l     = r_score_l;
  assign score_r     = r_score_r;
  assign game_over   = r_game_over;
  assign winner      = r_winner;

`ifdef MATCH_CTRL_ROUND_CNT_EN
  logic [3:0] r_round_cnt;
  logic       w_play_exit;
  logic       w_new_match;

  assign w_play_exit = (r_state == S_PLAY) && (point_l || point_r);
  assign w_new_match = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

  always_ff @(posedge clock) begin
    if (reset || w_new_match)                    r_round_cnt <= '0;
    else if (w_play_exit && r_round_cnt != '1)   r_round_cnt <= r_round_cnt + 4'd1;
  end

  assign round_cnt = r_round_cnt;
`endif

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: stimulus queues expected output snapshots per cycle,
// a negedge monitor pops and compares them.
module tb_match_controller;
  localparam int W = 7;
  localparam int P = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       point_l = 1'b0;
  logic       point_r = 1'b0;
  logic       field_clear, play_en, game_over;
  logic [2:0] score_l, score_r;
  logic [1:0] winner;
`ifdef MATCH_CTRL_ROUND_CNT_EN
  logic [3:0] round_cnt;
`endif

  match_controller #(.WIN_SCORE(W), .PAUSE_CYCLES(P)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .point_l(point_l),
    .point_r(point_r),
    .field_clear(field_clear),
    .play_en(play_en),
    .score_l(score_l),
    .score_r(score_r),
    .game_over(game_over),
    .winner(winner)
`ifdef MATCH_CTRL_ROUND_CNT_EN
    ,
    .round_cnt(round_cnt)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [10:0] vec;
    logic [3:0] rc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [2:0] m_sl = 0, m_sr = 0;
  logic [1:0] m_w = 0;
  logic [3:0] m_rc = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic fc, input logic pe, input logic go,
                          input logic [1:0] w);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.vec  = {fc, pe, m_sl, m_sr, go, w};
    e.rc   = m_rc;
    q.push_back(e);
  endtask

  task automatic exp_idle(input string nm);  push_exp(nm, 1'b1, 1'b0, 1'b0, 2'b00); endtask
  task automatic exp_play(input string nm);  push_exp(nm, 1'b0, 1'b1, 1'b0, 2'b00); endtask
  task automatic exp_pause(input string nm); push_exp(nm, 1'b1, 1'b0, 1'b0, 2'b00); endtask
  task automatic exp_done(input string nm);  push_exp(nm, 1'b0, 1'b0, 1'b1, m_w);   endtask

  // One PLAY exit: point pulse, then either DONE or a full pause and back to PLAY.
  task automatic play_round(input logic l, input logic r, input string nm);
    point_l = l;
    point_r = r;
    tick();
    point_l = 1'b0;
    point_r = 1'b0;
    if (l && !r) m_sl = m_sl + 3'd1;
    if (r && !l) m_sr = m_sr + 3'd1;
    if (m_rc != 4'hF) m_rc = m_rc + 4'd1;
    if (m_sl == 3'(W)) begin m_w = 2'b10; exp_done({nm, "_done"}); return; end
    if (m_sr == 3'(W)) begin m_w = 2'b01; exp_done({nm, "_done"}); return; end
    exp_pause({nm, "_pause"});
    for (int k = 0; k < P - 1; k++) begin
      point_r = (k == 0);
      tick();
      point_r = 1'b0;
      exp_pause({nm, "_pause"});
    end
    tick();
    exp_play({nm, "_play"});
  endtask

  initial begin : monitor
    exp_t       e;
    logic [10:0] act;
    logic       bad;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = {field_clear, play_en, score_l, score_r, game_over, winner};
        bad = (act !== e.vec) || (e.cyc != cyc);
`ifdef MATCH_CTRL_ROUND_CNT_EN
        if (round_cnt !== e.rc) bad = 1'b1;
`endif
        n_cmp++;
        if (bad) begin
          n_bad++;
          $display("FAIL %s cyc=%0d: got fc=%b pe=%b sl=%0d sr=%0d go=%b w=%b, required fc=%b pe=%b sl=%0d sr=%0d go=%b w=%b (rc req %0d)",
                   e.name, cyc, act[10], act[9], act[8:6], act[5:3], act[2], act[1:0],
                   e.vec[10], e.vec[9], e.vec[8:6], e.vec[5:3], e.vec[2], e.vec[1:0], e.rc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    tick();
    tick();
    exp_idle("reset");
    reset = 1'b0;
    tick();
    exp_idle("idle_hold");
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_idle("clear_entry");
    tick();
    exp_play("play_entry");
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_play("start_ignored_in_play");

    play_round(1'b0, 1'b1, "r1");
    play_round(1'b1, 1'b1, "draw");
    play_round(1'b1, 1'b0, "l1");
    play_round(1'b1, 1'b0, "l2");

    point_l = 1'b1;
    tick();
    point_l = 1'b0;
    m_sl = 3'd3;
    m_rc = m_rc + 4'd1;
    exp_pause("l3_pause1");
    tick();
    exp_pause("l3_pause2");
    reset = 1'b1;
    start = 1'b1;
    point_l = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    point_l = 1'b0;
    m_sl = 0; m_sr = 0; m_rc = 0;
    exp_idle("reset_mid_pause");
    tick();
    exp_idle("idle_after_reset");

    start = 1'b1;
    tick();
    start = 1'b0;
    exp_idle("clear2");
    tick();
    exp_play("play2");
    for (int i = 0; i < W; i++) play_round(1'b0, 1'b1, "rwin");

    point_l = 1'b1;
    point_r = 1'b1;
    tick();
    point_l = 1'b0;
    point_r = 1'b0;
    exp_done("done_draw_ignored");
    point_r = 1'b1;
    tick();
    point_r = 1'b0;
    exp_done("done_point_ignored");
    tick();
    exp_done("done_hold");

    start = 1'b1;
    tick();
    start = 1'b0;
    m_sl = 0; m_sr = 0; m_w = 0; m_rc = 0;
    exp_idle("restart_clear");
    tick();
    exp_play("restart_play");
    for (int i = 0; i < W; i++) play_round(1'b1, 1'b0, "lwin");

    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_sl = 0; m_sr = 0; m_w = 0; m_rc = 0;
    exp_idle("reset_from_done");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
